// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_if
// Brief    : Operand/opcode request and registered result/flag bundle for alu.
// Revision : 1.0
// ============================================================================
interface alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;

    modport master (
        output in_valid, a, b, op,
        input  result, out_valid, zero, carry, overflow, negative
    );

    modport slave (
        input  in_valid, a, b, op,
        output result, out_valid, zero, carry, overflow, negative
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Single-cycle-latency 16-op ALU with registered result and flags.
// Revision : 1.0
// ============================================================================
module alu #(
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_if.slave      bus
);
    localparam int       c_shw    = $clog2(WIDTH);
    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_not  = 4'd5;
    localparam logic [3:0] c_op_nand = 4'd6;
    localparam logic [3:0] c_op_nor  = 4'd7;
    localparam logic [3:0] c_op_shl  = 4'd8;
    localparam logic [3:0] c_op_shr  = 4'd9;
    localparam logic [3:0] c_op_sar  = 4'd10;
    localparam logic [3:0] c_op_rol  = 4'd11;
    localparam logic [3:0] c_op_ror  = 4'd12;
    localparam logic [3:0] c_op_inc  = 4'd13;
    localparam logic [3:0] c_op_dec  = 4'd14;
    localparam logic [3:0] c_op_slt  = 4'd15;

    logic [WIDTH-1:0] w_opb;
    logic             w_is_sub;
    logic [WIDTH:0]   w_addsub;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [c_shw-1:0] w_sh;
    logic [c_shw:0]   w_rsh;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH:0]   w_sar;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic             r_zero;
    logic             r_carry;
    logic             r_overflow;
    logic             r_negative;

    // INC/DEC reuse the ADD/SUB datapath with a constant second operand of 1.
    assign w_opb    = (bus.op == c_op_inc || bus.op == c_op_dec) ? WIDTH'(1) : bus.b;
    assign w_is_sub = (bus.op == c_op_sub || bus.op == c_op_dec);
    assign w_addsub = w_is_sub ? ({1'b0, bus.a} - {1'b0, w_opb})
                               : ({1'b0, bus.a} + {1'b0, w_opb});
    assign w_add_ovf = (bus.a[WIDTH-1] == w_opb[WIDTH-1]) &&
                       (w_addsub[WIDTH-1] != bus.a[WIDTH-1]);
    assign w_sub_ovf = (bus.a[WIDTH-1] != w_opb[WIDTH-1]) &&
                       (w_addsub[WIDTH-1] != bus.a[WIDTH-1]);

    // Shifts run one bit wider so the departing bit lands in the extra slot;
    // a zero shift leaves that slot at 0, giving carry 0 for free.
    assign w_sh  = bus.b[c_shw-1:0];
    assign w_rsh = (c_shw+1)'(WIDTH) - {1'b0, w_sh};
    assign w_shl = {1'b0, bus.a} << w_sh;
    assign w_shr = {bus.a, 1'b0} >> w_sh;
    assign w_sar = $signed({bus.a, 1'b0}) >>> w_sh;
    assign w_rol = (bus.a << w_sh) | (bus.a >> w_rsh);
    assign w_ror = (bus.a >> w_sh) | (bus.a << w_rsh);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (bus.op)
            c_op_add, c_op_inc: begin
                w_res   = w_addsub[WIDTH-1:0];
                w_carry = w_addsub[WIDTH];
                w_ovf   = w_add_ovf;
            end
            c_op_sub, c_op_dec: begin
                w_res   = w_addsub[WIDTH-1:0];
                w_carry = w_addsub[WIDTH];
                w_ovf   = w_sub_ovf;
            end
            c_op_and:  w_res = bus.a & bus.b;
            c_op_or:   w_res = bus.a | bus.b;
            c_op_xor:  w_res = bus.a ^ bus.b;
            c_op_not:  w_res = ~bus.a;
            c_op_nand: w_res = ~(bus.a & bus.b);
            c_op_nor:  w_res = ~(bus.a | bus.b);
            c_op_shl: begin
                w_res   = w_shl[WIDTH-1:0];
                w_carry = w_shl[WIDTH];
            end
            c_op_shr: begin
                w_res   = w_shr[WIDTH:1];
                w_carry = w_shr[0];
            end
            c_op_sar: begin
                w_res   = w_sar[WIDTH:1];
                w_carry = w_sar[0];
            end
            c_op_rol:  w_res = w_rol;
            c_op_ror:  w_res = w_ror;
            c_op_slt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default:   w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b1;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_negative  <= 1'b0;
        end else if (bus.in_valid) begin
            r_result    <= w_res;
            r_out_valid <= 1'b1;
            r_zero      <= (w_res == '0);
            r_carry     <= w_carry;
            r_overflow  <= w_ovf;
            r_negative  <= w_res[WIDTH-1];
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.result    = r_result;
    assign bus.out_valid = r_out_valid;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_overflow;
    assign bus.negative  = r_negative;
endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Brief    : Self-checking bench for alu against an integer reference model.
// Revision : 1.0
// ============================================================================
module tb_alu;
    localparam int c_w = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model of the registered outputs as they should stand after the last edge
    int   m_res = 0;
    bit   m_valid = 0, m_zero = 1, m_carry = 0, m_ovf = 0, m_neg = 0;

    alu_if #(.WIDTH(c_w)) bus ();

    alu #(.WIDTH(c_w)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic ref_model(input int ua, input int ub, input int op,
                             output int res, output bit c, output bit ov);
        int sa, sb, n, s;
        sa = sx(ua); sb = sx(ub); n = ub % 8;
        res = 0; c = 0; ov = 0;
        if (op == 13) begin ub = 1; sb = 1; op = 0; end
        if (op == 14) begin ub = 1; sb = 1; op = 1; end
        case (op)
            0:  begin res = (ua + ub) % 256; c = (ua + ub) > 255;
                      s = sa + sb; ov = (s > 127) || (s < -128); end
            1:  begin res = (ua - ub + 256) % 256; c = ua < ub;
                      s = sa - sb; ov = (s > 127) || (s < -128); end
            2:  res = ua & ub;
            3:  res = ua | ub;
            4:  res = ua ^ ub;
            5:  res = 255 - ua;
            6:  res = 255 - (ua & ub);
            7:  res = 255 - (ua | ub);
            8:  begin res = (ua * (1 << n)) % 256; c = (n > 0) && (((ua >> (8 - n)) & 1) == 1); end
            9:  begin res = ua / (1 << n); c = (n > 0) && (((ua >> (n - 1)) & 1) == 1); end
            10: begin res = (sa >>> n) & 255; c = (n > 0) && (((ua >> (n - 1)) & 1) == 1); end
            11: begin res = ua; repeat (n) res = ((res * 2) % 256) + (res / 128); end
            12: begin res = ua; repeat (n) res = (res / 2) + ((res % 2) * 128); end
            15: res = (sa < sb) ? 1 : 0;
            default: res = 0;
        endcase
    endtask

    // Drive one cycle of inputs from the negedge, advance the model across the
    // following rising edge, then compare every output at the next negedge.
    task automatic step(input bit r, input bit v, input int ta, input int tb_, input int top);
        int res; bit c, ov;
        rst          = r;
        bus.in_valid = v;
        bus.a        = 8'(ta);
        bus.b        = 8'(tb_);
        bus.op       = 4'(top);
        @(negedge clk);
        if (r) begin
            m_res = 0; m_valid = 0; m_zero = 1; m_carry = 0; m_ovf = 0; m_neg = 0;
        end else if (v) begin
            ref_model(ta, tb_, top, res, c, ov);
            m_res = res; m_valid = 1; m_carry = c; m_ovf = ov;
            m_zero = (res == 0); m_neg = (res >= 128);
        end else begin
            m_valid = 0;
        end
        chk("result",    32'(bus.result),   32'(m_res));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("zero",      32'(bus.zero),     32'(m_zero));
        chk("carry",     32'(bus.carry),    32'(m_carry));
        chk("overflow",  32'(bus.overflow), 32'(m_ovf));
        chk("negative",  32'(bus.negative), 32'(m_neg));
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_result", 32'(bus.result), 32'h0);
        chk("rst_zero",   32'(bus.zero),   32'h1);

        // Directed corner cases with literal expectations
        step(0, 1, 8'hFF, 8'h01, 0);
        chk("add_ff_res", 32'(bus.result), 32'h00);
        chk("add_ff_z",   32'(bus.zero),   32'h1);
        chk("add_ff_c",   32'(bus.carry),  32'h1);
        chk("add_ff_v",   32'(bus.overflow), 32'h0);
        chk("add_ff_ov",  32'(bus.out_valid), 32'h1);
        step(0, 1, 8'h7F, 8'h01, 0);
        chk("add_7f_res", 32'(bus.result), 32'h80);
        chk("add_7f_v",   32'(bus.overflow), 32'h1);
        chk("add_7f_n",   32'(bus.negative), 32'h1);
        chk("add_7f_c",   32'(bus.carry),  32'h0);
        step(0, 1, 8'h05, 8'h07, 1);
        chk("sub_res",    32'(bus.result), 32'hFE);
        chk("sub_borrow", 32'(bus.carry),  32'h1);
        chk("sub_n",      32'(bus.negative), 32'h1);
        step(0, 1, 8'h80, 8'h01, 15);
        chk("slt_res",    32'(bus.result), 32'h01);
        step(0, 1, 8'h90, 8'h02, 10);
        chk("sar_res",    32'(bus.result), 32'hE4);
        chk("sar_c",      32'(bus.carry),  32'h0);
        step(0, 1, 8'h81, 8'h01, 11);
        chk("rol_res",    32'(bus.result), 32'h03);
        step(0, 1, 8'h81, 8'h01, 8);
        chk("shl_res",    32'(bus.result), 32'h02);
        chk("shl_c",      32'(bus.carry),  32'h1);
        step(0, 1, 8'h5A, 8'hF8, 12);
        chk("ror0_res",   32'(bus.result), 32'h5A);
        step(0, 1, 8'h80, 8'h00, 14);
        chk("dec_80_v",   32'(bus.overflow), 32'h1);
        step(0, 0, 8'h11, 8'h22, 0);
        chk("idle_ov",    32'(bus.out_valid), 32'h0);
        chk("idle_hold",  32'(bus.result), 32'h7F);

        // Streaming all sixteen ops back to back
        for (int k = 0; k < 16; k++)
            step(0, 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), k);
        step(0, 0, 0, 0, 0);

        // Reset wins over a simultaneous request; the op must never surface
        step(0, 1, 8'h10, 8'h20, 0);
        step(1, 1, 3, 4, 0);
        chk("rstpri_res", 32'(bus.result), 32'h0);
        chk("rstpri_z",   32'(bus.zero),   32'h1);
        chk("rstpri_ov",  32'(bus.out_valid), 32'h0);
        step(0, 0, 0, 0, 0);
        chk("no_leak",    32'(bus.result == 8'h07), 32'h0);
        step(0, 1, 8'h01, 8'h01, 0);
        chk("first_after_rst", 32'(bus.result), 32'h02);

        // Randomised traffic with sparse resets and idle cycles
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 15)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; all requirements below use WIDTH=8 for concrete values.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port in_valid, input, 1, qualifies a/b/op for capture this cycle.
REQ-006 Port a, input, WIDTH, operand A.
REQ-007 Port b, input, WIDTH, operand B.
REQ-008 Port op, input, 4, operation select.
REQ-009 Port result, output, WIDTH, registered result.
REQ-010 Port out_valid, output, 1, result/flags hold a new value this cycle.
REQ-011 Port zero, output, 1, result == 0.
REQ-012 Port carry, output, 1, carry/borrow/shifted-out bit.
REQ-013 Port overflow, output, 1, signed overflow.
REQ-014 Port negative, output, 1, result[WIDTH-1].

Function
REQ-015 op encoding SHALL be: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 NAND; 7 NOR; 8 SHL a by b[2:0]; 9 SHR logical a by b[2:0]; 10 SAR arithmetic a by b[2:0]; 11 ROL a by b[2:0]; 12 ROR a by b[2:0]; 13 INC a+1; 14 DEC a-1; 15 SLT signed, result 1 if signed a < signed b, else 0.
REQ-016 All arithmetic SHALL be modulo 2^WIDTH; the result SHALL wrap, with no saturation.
REQ-017 carry SHALL be: ADD/INC carry-out; SUB/DEC borrow (1 when unsigned a < subtrahend); SHL the last bit shifted out of MSB; SHR/SAR the last bit shifted out of LSB; shift amount 0 gives carry 0; all other ops 0.
REQ-018 overflow SHALL be: ADD/INC operands of the same sign with a result of the opposite sign; SUB/DEC operands of differing sign with the result sign differing from a; all other ops 0.
REQ-019 zero and negative SHALL be derived from the final result value for every op.
REQ-020 Latency SHALL be 1 cycle: when in_valid=1 at edge N, result, flags and out_valid=1 SHALL appear after edge N.
REQ-021 When in_valid=0 at an edge, out_valid SHALL go to 0 and result and flags SHALL hold their previous values.
REQ-022 Back-to-back in_valid SHALL give one output per cycle with no bubbles; there SHALL be no backpressure.
REQ-023 Rotates SHALL be by b[2:0] mod WIDTH; rotation by 0 returns a.
REQ-024 Unused upper bits of b for shift/rotate ops SHALL be ignored.

Reset
REQ-025 When rst=1 at a rising edge, result SHALL become 0, out_valid 0, carry 0, overflow 0, negative 0, and zero 1.
REQ-026 rst SHALL take priority over in_valid; an operation presented during reset SHALL be discarded and SHALL NOT appear after reset is released.
REQ-027 The first valid output after reset deassertion SHALL come from the first in_valid cycle with rst=0.

Verification
REQ-028 ADD a=0xFF, b=0x01 -> result 0x00, zero=1, carry=1, overflow=0, out_valid=1 one cycle later.
REQ-029 ADD a=0x7F, b=0x01 -> result 0x80, overflow=1, negative=1, carry=0.
REQ-030 SUB a=0x05, b=0x07 -> result 0xFE, carry(borrow)=1, negative=1; SLT a=0x80, b=0x01 -> result 0x01.
REQ-031 SAR a=0x90, b=0x02 -> result 0xE4, carry=0; ROL a=0x81, b=0x01 -> result 0x03; SHL a=0x81, b=0x01 -> result 0x02, carry=1.
REQ-032 Streaming: ops 0..15 applied on consecutive cycles with in_valid=1 -> 16 consecutive out_valid pulses, each matching a reference model; in_valid=0 in a cycle -> out_valid=0 and outputs held.
REQ-033 rst asserted while in_valid=1 with ADD 3+4 -> after the edge result=0, zero=1, out_valid=0; no 0x07 appears after release.
